// File: rtl/op_emitter.sv
// One-hot instruction-class encoder feeding a small opcode FIFO, with a HALT latch and sticky error.
// Optional delivered-word counter (issue_count) is built when OP_EMITTER_COUNT_EN is defined.
module op_emitter #(
    parameter int unsigned DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [10:0] req_class,
    input  logic [3:0]  req_mod,
    input  logic [23:0] req_payload,
    output logic        op_valid,
    input  logic        op_ready,
    output logic [31:0] Op_code,
    output logic        halted,
    input  logic        resume,
    output logic        err
`ifdef OP_EMITTER_COUNT_EN
    ,
    output logic [15:0] issue_count
`endif
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = PW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
    localparam int unsigned HALT_BIT = 6;

    typedef enum logic [0:0] {StRun, StHalted} state_e;

    state_e        state_q;
    logic [PW-1:0] wr_ptr_q;
    logic [PW-1:0] rd_ptr_q;
    logic [CW-1:0] count_q;
    logic [31:0]   mem_q [DEPTH];
    logic          err_q;

    logic          full;
    logic          empty;
    logic          req_hs;
    logic          op_hs;
    logic          legal;
    logic          push;
    logic          pop;
    logic [3:0]    class_code;

    always_comb begin
        class_code = 4'h0;
        for (int i = 0; i < 11; i++) begin
            if (req_class[i]) class_code = 4'(i);
        end
    end

    // Exactly one bit set: non-zero and clearing the lowest set bit leaves nothing.
    assign legal = (req_class != 11'd0) && ((req_class & (req_class - 11'd1)) == 11'd0);

    assign full      = (count_q == FULL_CNT);
    assign empty     = (count_q == '0);
    assign req_ready = (state_q == StRun) && !full;
    assign req_hs    = req_valid && req_ready;
    assign op_valid  = !empty;
    assign op_hs     = op_valid && op_ready;
    assign push      = req_hs && legal;
    assign pop       = op_hs;
    assign Op_code   = empty ? 32'h0 : mem_q[rd_ptr_q];
    assign halted    = (state_q == StHalted);
    assign err       = err_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= StRun;
            err_q    <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (req_hs && !legal) err_q <= 1'b1;

            unique case (state_q)
                StRun:    if (push && req_class[HALT_BIT]) state_q <= StHalted;
                StHalted: if (resume) state_q <= StRun;
                default:  state_q <= StRun;
            endcase

            if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
            if (push && !pop)      count_q <= count_q + CW'(1);
            else if (!push && pop) count_q <= count_q - CW'(1);
        end
    end

    // Storage needs no reset: occupancy gates every read.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= {req_mod, class_code, req_payload};
    end

`ifdef OP_EMITTER_COUNT_EN
    logic [15:0] issue_count_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)      issue_count_q <= 16'h0;
        else if (pop) issue_count_q <= issue_count_q + 16'd1;
    end

    assign issue_count = issue_count_q;
`endif

endmodule

// File: tb/tb_op_emitter.sv
// Directed self-checking bench for op_emitter (DEPTH = 4); inputs change and outputs are sampled
// on the falling edge, state updates on the rising edge.
module tb_op_emitter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [10:0] req_class = 11'h0;
    logic [3:0]  req_mod = 4'h0;
    logic [23:0] req_payload = 24'h0;
    logic        op_valid;
    logic        op_ready = 1'b0;
    logic [31:0] Op_code;
    logic        halted;
    logic        resume = 1'b0;
    logic        err;
`ifdef OP_EMITTER_COUNT_EN
    logic [15:0] issue_count;
`endif

    int compared = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    op_emitter #(.DEPTH(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_class  (req_class),
        .req_mod    (req_mod),
        .req_payload(req_payload),
        .op_valid   (op_valid),
        .op_ready   (op_ready),
        .Op_code    (Op_code),
        .halted     (halted),
        .resume     (resume),
        .err        (err)
`ifdef OP_EMITTER_COUNT_EN
        ,
        .issue_count(issue_count)
`endif
    );

    task automatic test_reset();
        #2;
        compared++; if (req_ready !== 1'b1) begin mismatched++; $display("FAIL reset_req_ready got %b want 1", req_ready); end
        compared++; if (op_valid !== 1'b0) begin mismatched++; $display("FAIL reset_op_valid got %b want 0", op_valid); end
        compared++; if (Op_code !== 32'h0) begin mismatched++; $display("FAIL reset_op_code got %h want 00000000", Op_code); end
        compared++; if (halted !== 1'b0) begin mismatched++; $display("FAIL reset_halted got %b want 0", halted); end
        compared++; if (err !== 1'b0) begin mismatched++; $display("FAIL reset_err got %b want 0", err); end
`ifdef OP_EMITTER_COUNT_EN
        compared++; if (issue_count !== 16'h0) begin mismatched++; $display("FAIL reset_count got %h want 0000", issue_count); end
`endif
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_class_sweep();
        logic [31:0] exp;
        op_ready = 1'b1;
        for (int i = 0; i < 11; i++) begin
            @(negedge clk);
            req_valid = 1'b1; req_class = 11'(1 << i); req_mod = 4'h5; req_payload = 24'h123456;
            exp = {4'h5, 4'(i), 24'h123456};
            compared++; if (req_ready !== 1'b1) begin mismatched++; $display("FAIL sweep_ready class %0d got %b want 1", i, req_ready); end
            @(negedge clk);
            req_valid = 1'b0;
            compared++; if (op_valid !== 1'b1 || Op_code !== exp) begin mismatched++; $display("FAIL sweep_word class %0d got v=%b %h want v=1 %h", i, op_valid, Op_code, exp); end
            if (i == 6) begin
                compared++; if (halted !== 1'b1) begin mismatched++; $display("FAIL sweep_halted got %b want 1", halted); end
                resume = 1'b1;
            end
            @(negedge clk);
            resume = 1'b0;
            compared++; if (op_valid !== 1'b0 || halted !== 1'b0) begin mismatched++; $display("FAIL sweep_drain class %0d got v=%b h=%b want v=0 h=0", i, op_valid, halted); end
        end
    endtask

    task automatic test_back_pressure();
        logic [31:0] exp;
        op_ready = 1'b0;
        req_class = 11'h001; req_mod = 4'h0;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            req_valid = 1'b1; req_payload = 24'(k);
            compared++; if (req_ready !== 1'b1) begin mismatched++; $display("FAIL bp_ready_%0d got %b want 1", k, req_ready); end
        end
        @(negedge clk);
        req_payload = 24'd5;
        compared++; if (req_ready !== 1'b0) begin mismatched++; $display("FAIL bp_full_ready got %b want 0", req_ready); end
        compared++; if (Op_code !== 32'h00000001) begin mismatched++; $display("FAIL bp_head got %h want 00000001", Op_code); end
        op_ready = 1'b1;
        @(negedge clk);
        compared++; if (req_ready !== 1'b1 || Op_code !== 32'h00000002) begin mismatched++; $display("FAIL bp_after_pop got r=%b %h want r=1 00000002", req_ready, Op_code); end
        @(negedge clk);
        req_valid = 1'b0;
        for (int k = 3; k <= 5; k++) begin
            exp = 32'(k);
            compared++; if (op_valid !== 1'b1 || Op_code !== exp) begin mismatched++; $display("FAIL bp_drain_%0d got v=%b %h want v=1 %h", k, op_valid, Op_code, exp); end
            @(negedge clk);
        end
        compared++; if (op_valid !== 1'b0) begin mismatched++; $display("FAIL bp_empty got %b want 0", op_valid); end
    endtask

    task automatic test_halt();
        op_ready = 1'b0; req_mod = 4'h0;
        @(negedge clk);
        req_valid = 1'b1; req_class = 11'h008; req_payload = 24'h0000AA;
        @(negedge clk);
        req_class = 11'h040; req_payload = 24'h0000BB;
        compared++; if (req_ready !== 1'b1) begin mismatched++; $display("FAIL halt_ready_before got %b want 1", req_ready); end
        @(negedge clk);
        req_class = 11'h001; req_payload = 24'h0000CC;
        compared++; if (halted !== 1'b1 || req_ready !== 1'b0) begin mismatched++; $display("FAIL halt_state got h=%b r=%b want h=1 r=0", halted, req_ready); end
        compared++; if (Op_code !== 32'h030000AA) begin mismatched++; $display("FAIL halt_jump_word got %h want 030000AA", Op_code); end
        op_ready = 1'b1;
        @(negedge clk);
        compared++; if (Op_code !== 32'h060000BB || req_ready !== 1'b0) begin mismatched++; $display("FAIL halt_halt_word got %h r=%b want 060000BB r=0", Op_code, req_ready); end
        @(negedge clk);
        compared++; if (op_valid !== 1'b0 || halted !== 1'b1) begin mismatched++; $display("FAIL halt_drained got v=%b h=%b want v=0 h=1", op_valid, halted); end
        resume = 1'b1;
        @(negedge clk);
        resume = 1'b0;
        compared++; if (halted !== 1'b0 || req_ready !== 1'b1 || op_valid !== 1'b0) begin mismatched++; $display("FAIL halt_resume got h=%b r=%b v=%b want h=0 r=1 v=0", halted, req_ready, op_valid); end
        @(negedge clk);
        req_valid = 1'b0;
        compared++; if (op_valid !== 1'b1 || Op_code !== 32'h000000CC) begin mismatched++; $display("FAIL halt_alu_word got v=%b %h want v=1 000000CC", op_valid, Op_code); end
        @(negedge clk);
    endtask

    task automatic test_illegal();
        op_ready = 1'b1;
        compared++; if (err !== 1'b0) begin mismatched++; $display("FAIL illegal_err_before got %b want 0", err); end
        @(negedge clk);
        req_valid = 1'b1; req_class = 11'h000;
        compared++; if (req_ready !== 1'b1) begin mismatched++; $display("FAIL illegal_ready_zero got %b want 1", req_ready); end
        @(negedge clk);
        compared++; if (err !== 1'b1 || op_valid !== 1'b0) begin mismatched++; $display("FAIL illegal_zero got e=%b v=%b want e=1 v=0", err, op_valid); end
        req_class = 11'h041;
        compared++; if (req_ready !== 1'b1) begin mismatched++; $display("FAIL illegal_ready_multi got %b want 1", req_ready); end
        @(negedge clk);
        req_valid = 1'b0;
        compared++; if (op_valid !== 1'b0 || halted !== 1'b0 || err !== 1'b1) begin mismatched++; $display("FAIL illegal_multi got v=%b h=%b e=%b want v=0 h=0 e=1", op_valid, halted, err); end
        @(negedge clk);
        compared++; if (err !== 1'b1 || req_ready !== 1'b1) begin mismatched++; $display("FAIL illegal_sticky got e=%b r=%b want e=1 r=1", err, req_ready); end
    endtask

    task automatic test_reset_mid();
        op_ready = 1'b0;
        req_valid = 1'b1; req_class = 11'h001; req_payload = 24'h1;
        @(negedge clk);
        req_payload = 24'h2;
        @(negedge clk);
        req_class = 11'h040; req_payload = 24'h3;
        @(negedge clk);
        req_valid = 1'b0;
        compared++; if (op_valid !== 1'b1 || halted !== 1'b1 || err !== 1'b1) begin mismatched++; $display("FAIL mid_setup got v=%b h=%b e=%b want v=1 h=1 e=1", op_valid, halted, err); end
        #2 rst = 1'b1;
        #1;
        compared++; if (op_valid !== 1'b0 || halted !== 1'b0 || err !== 1'b0) begin mismatched++; $display("FAIL mid_async got v=%b h=%b e=%b want v=0 h=0 e=0", op_valid, halted, err); end
        compared++; if (req_ready !== 1'b1 || Op_code !== 32'h0) begin mismatched++; $display("FAIL mid_ready got r=%b %h want r=1 00000000", req_ready, Op_code); end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        compared++; if (op_valid !== 1'b0 || req_ready !== 1'b1) begin mismatched++; $display("FAIL mid_after got v=%b r=%b want v=0 r=1", op_valid, req_ready); end
    endtask

`ifdef OP_EMITTER_COUNT_EN
    task automatic test_count();
        compared++; if (issue_count !== 16'h0) begin mismatched++; $display("FAIL count_cleared got %h want 0000", issue_count); end
        op_ready = 1'b1; req_class = 11'h001; req_payload = 24'h0;
        @(negedge clk);
        req_valid = 1'b1;
        repeat (16'hFFFE) @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        compared++; if (issue_count !== 16'hFFFE) begin mismatched++; $display("FAIL count_preload got %h want FFFE", issue_count); end
        req_valid = 1'b1;
        repeat (3) @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        compared++; if (issue_count !== 16'h0001) begin mismatched++; $display("FAIL count_wrap got %h want 0001", issue_count); end
    endtask
`endif

    initial begin
        test_reset();
        test_class_sweep();
        test_back_pressure();
        test_halt();
        test_illegal();
        test_reset_mid();
`ifdef OP_EMITTER_COUNT_EN
        test_count();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/op_emitter.md
# op_emitter

Encodes one-hot instruction-class requests into 32-bit opcode words and buffers them for the execute path. It is the producing end of the opcode class field: an opcode class decoder downstream reads the class back from bits [27:24]. A small FIFO with valid/ready handshakes sits between the request side and the opcode consumer. A HALT latch stops intake after a HALT instruction is accepted.

## Interface
Parameters:
- DEPTH, 4, FIFO entries; power of two, minimum 2.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- req_valid  in  1  request present.
- req_ready  out  1  request accepted this cycle when high together with req_valid.
- req_class  in  11  one-hot class select. Bit 0 ALU, 1 FALU, 2 COND, 3 JUMP, 4 RAM_SAVE, 5 RAM_LOAD, 6 HALT, 7 STACK_PUSH, 8 STACK_POP, 9 CALL, 10 RET.
- req_mod  in  4  modifier nibble, placed in Op_code[31:28].
- req_payload  in  24  operand field, placed in Op_code[23:0].
- op_valid  out  1  Op_code holds a valid word.
- op_ready  in  1  consumer takes the word when high together with op_valid.
- Op_code  out  32  encoded opcode at the FIFO head.
- halted  out  1  emitter is in the HALTED state.
- resume  in  1  leave HALTED.
- err  out  1  sticky flag for an illegal request.
- issue_count  out  16  words delivered. Present only with OP_EMITTER_COUNT_EN.

## Operation
- Encoding: class code = index of the set bit in req_class (0x0–0xA).
  - Op_code = {req_mod, class[3:0], req_payload}.
  - Encoding happens at acceptance; the FIFO stores the encoded word.
- State machine:
  - RUN (reset state). Accepting a legal HALT request moves the block to HALTED on the next edge. The HALT word itself is enqueued.
  - HALTED. req_ready = 0. The FIFO continues to drain. resume = 1 returns to RUN on the next edge, whether or not the FIFO is empty. resume is ignored in RUN.
- req_ready = (state == RUN) && !full. There is no pass-through when full, even if a pop occurs in the same cycle.
- Illegal request: req_class is zero or has more than one bit set.
  - The handshake completes normally and nothing is enqueued.
  - err is set on the next edge and stays set until rst.
  - State does not change, even if bit 6 (HALT) is among the set bits.
- FIFO:
  - Push on req handshake with a legal class.
  - Pop on op handshake.
  - Simultaneous push and pop keeps occupancy unchanged.
  - Read and write pointers wrap modulo DEPTH.
  - op_valid = !empty. Op_code = head entry, or 0 when empty.
- Reset mid-operation: FIFO contents are discarded, state goes to RUN, err clears, issue_count clears.

## Timing
- Reset values:
  - req_ready = 1, op_valid = 0, Op_code = 0, halted = 0, err = 0, issue_count = 0.
- Latency: a request accepted at edge N appears on Op_code/op_valid after edge N. There is no combinational path from req to op.
- req_ready depends only on registered state; it has no combinational dependence on op_ready.
- Op_code and op_valid are stable while op_valid = 1 and op_ready = 0.
- halted rises on the edge after HALT acceptance. The following request sees req_ready = 0.

## Configuration
- OP_EMITTER_COUNT_EN defined:
  - A 16-bit issue_count register and port exist.
  - The count increments on every op handshake and wraps from 0xFFFF to 0x0000.
- OP_EMITTER_COUNT_EN undefined:
  - The port and register are absent.
  - All other behaviour is identical.

## Test plan
- Class sweep: after reset, send each of the 11 one-hot classes with req_mod = 0x5 and req_payload = 0x123456, holding op_ready = 1.
  - Required: Op_code sequence 0x50123456, 0x51123456 … 0x5A123456, each one cycle after its acceptance. For HALT, pulse resume.
- Full/back-pressure: DEPTH = 4, op_ready = 0, push 5 legal requests.
  - Required: req_ready drops after the 4th acceptance.
  - Required: raising op_ready drains 4 words in order, and the 5th request is then accepted.
- Halt: request JUMP, HALT, then ALU.
  - Required: halted = 1 after the HALT acceptance and the ALU request is stalled.
  - Required: JUMP and HALT words drain normally.
  - Required: a resume pulse lets the ALU word (class nibble 0x0) enqueue.
- Illegal: send req_class = 0 and then req_class = 0x041 (HALT and ALU set).
  - Required: both handshakes complete, nothing is enqueued, err = 1 (sticky), and halted remains 0.
- Reset mid-stream: with 3 words queued and HALTED, assert rst for one cycle.
  - Required: op_valid = 0, halted = 0, err = 0 immediately (asynchronous), and req_ready = 1.
- OP_EMITTER_COUNT_EN: with issue_count preloaded to 0xFFFE via 0xFFFE deliveries, deliver 3 words.
  - Required: issue_count reads 0x0001.
